scan_decoder: RTL



---
 rtl/scan_decoder_if.sv | 23 ++
 rtl/scan_decoder.sv | 125 ++++++++++++
 2 files changed

// File: rtl/scan_decoder_if.sv
// Select/scan bus between the LED-matrix controller (master) and scan_decoder (slave).
interface scan_decoder_if #(
  parameter int SEL_WIDTH = 3,
  parameter int DIV_WIDTH = 8
);
  logic                      Enable;
  logic                      Mode;
  logic [SEL_WIDTH-1:0]      Sel;
  logic [DIV_WIDTH-1:0]      Divider;
  logic [(1<<SEL_WIDTH)-1:0] DecoderOut;
  logic [SEL_WIDTH-1:0]      CurSel;
  logic                      FrameStart;

  modport master (
    output Enable, Mode, Sel, Divider,
    input  DecoderOut, CurSel, FrameStart
  );

  modport slave (
    input  Enable, Mode, Sel, Divider,
    output DecoderOut, CurSel, FrameStart
  );
endinterface

// File: rtl/scan_decoder.sv
// Registered one-hot row/column decoder with auto-scan sequencer for the LED matrix.
// Optional blank cycle on every index change when SCAN_DECODER_BLANKING_EN is defined.
module scan_decoder #(
  parameter int SEL_WIDTH = 3,
  parameter int DIV_WIDTH = 8
) (
  input logic           Clock,
  input logic           nReset,
  scan_decoder_if.slave bus
);
  localparam int N = 1 << SEL_WIDTH;

  logic [SEL_WIDTH-1:0] r_idx, w_idx_nx;
  logic [SEL_WIDTH-1:0] r_cur, w_cur_nx;
  logic [DIV_WIDTH-1:0] r_pre, w_pre_nx;
  logic [N-1:0]         r_dec, w_dec_nx;
  logic                 r_fs, w_fs_nx;
  logic                 r_mode, w_mode_nx;
  logic                 r_pend, w_pend_nx;
  logic                 r_wrap, w_wrap_nx;
  logic                 w_tick;
  logic                 w_last;

  function automatic logic [N-1:0] onehot(input logic [SEL_WIDTH-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

`ifdef SCAN_DECODER_BLANKING_EN
  // The reveal cycle after a blank never ticks, so Divider=0 alternates blank/one-hot.
  assign w_tick = !r_pend && (r_pre >= bus.Divider);
`else
  assign w_tick = (r_pre >= bus.Divider);
`endif
  assign w_last = (r_idx == SEL_WIDTH'(N - 1));

  always_comb begin
    w_idx_nx  = r_idx;
    w_cur_nx  = r_cur;
    w_pre_nx  = r_pre;
    w_mode_nx = r_mode;
    w_pend_nx = r_pend;
    w_wrap_nx = r_wrap;
    w_dec_nx  = '0;
    w_fs_nx   = 1'b0;
    if (bus.Enable) begin
      w_mode_nx = bus.Mode;
      if (!bus.Mode) begin
`ifdef SCAN_DECODER_BLANKING_EN
        w_wrap_nx = 1'b0;
        if (bus.Sel == r_cur) begin
          w_dec_nx  = onehot(bus.Sel);
          w_pend_nx = 1'b0;
        end else if (r_pend && (bus.Sel == r_idx)) begin
          w_dec_nx  = onehot(bus.Sel);
          w_cur_nx  = bus.Sel;
          w_pend_nx = 1'b0;
        end else begin
          // Park the new target in the index register and blank for one cycle.
          w_idx_nx  = bus.Sel;
          w_pend_nx = 1'b1;
        end
`else
        w_dec_nx = onehot(bus.Sel);
        w_cur_nx = bus.Sel;
`endif
      end else if (!r_mode) begin
        w_idx_nx  = bus.Sel;
        w_pre_nx  = '0;
        w_dec_nx  = onehot(bus.Sel);
        w_cur_nx  = bus.Sel;
        w_pend_nx = 1'b0;
        w_wrap_nx = 1'b0;
      end else if (w_tick) begin
        w_pre_nx = '0;
        w_idx_nx = r_idx + 1'b1;
`ifdef SCAN_DECODER_BLANKING_EN
        w_pend_nx = 1'b1;
        w_wrap_nx = w_last;
`else
        w_dec_nx = onehot(r_idx + 1'b1);
        w_cur_nx = r_idx + 1'b1;
        w_fs_nx  = w_last;
`endif
      end else begin
        w_pre_nx = r_pre + 1'b1;
        w_dec_nx = onehot(r_idx);
        w_cur_nx = r_idx;
`ifdef SCAN_DECODER_BLANKING_EN
        w_fs_nx   = r_pend && r_wrap;
        w_pend_nx = 1'b0;
        w_wrap_nx = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_idx  <= '0;
      r_cur  <= '0;
      r_pre  <= '0;
      r_dec  <= '0;
      r_fs   <= 1'b0;
      r_mode <= 1'b0;
      r_pend <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_idx  <= w_idx_nx;
      r_cur  <= w_cur_nx;
      r_pre  <= w_pre_nx;
      r_dec  <= w_dec_nx;
      r_fs   <= w_fs_nx;
      r_mode <= w_mode_nx;
      r_pend <= w_pend_nx;
      r_wrap <= w_wrap_nx;
    end
  end

  assign bus.DecoderOut = r_dec;
  assign bus.CurSel     = r_cur;
  assign bus.FrameStart = r_fs;
endmodule
